// File: rtl/seq_divider16by8.sv
// Sequential restoring divider: N_WIDTH-bit dividend / D_WIDTH-bit divisor.
// Produces one quotient bit per clock and uses valid/ready handshakes on both
// sides. A zero divisor bypasses the iteration and flags div_by_zero.
module seq_divider16by8 #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_WIDTH-1:0] quotient,
  output logic [D_WIDTH-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // q doubles as dividend shifter and quotient accumulator.
  logic [N_WIDTH-1:0] q;
  logic [D_WIDTH-1:0] d;
  // The partial remainder is always below the divisor, so its (D_WIDTH+1)-th
  // bit is permanently zero and is not stored; the trial value t keeps it.
  logic [D_WIDTH-1:0] r;
  logic [CW-1:0]      count;
  logic               dbz;

  logic [D_WIDTH:0]   t;
  logic               fits;
  logic               accept;
  logic               release_out;

  // Trial shift-in and compare for the current iteration, plus handshakes.
  always_comb begin
    t           = {r, q[N_WIDTH-1]};
    fits        = (t >= {1'b0, d});
    accept      = in_valid && (state == IDLE);
    release_out = out_ready && (state == DONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (divisor != '0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (count == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (release_out) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring iteration and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      d     <= '0;
      r     <= '0;
      count <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            if (divisor != '0) begin
              q   <= dividend;
              d   <= divisor;
              r   <= '0;
              dbz <= 1'b0;
            end else begin
              q   <= '1;
              r   <= dividend[D_WIDTH-1:0];
              dbz <= 1'b1;
            end
          end
        end
        BUSY: begin
          q     <= {q[N_WIDTH-2:0], fits};
          // When fits, t - d < d fits in D_WIDTH bits, so the low-bit
          // subtraction equals the full-width one.
          r     <= fits ? (t[D_WIDTH-1:0] - d) : t[D_WIDTH-1:0];
          count <= count + CW'(1);
        end
        DONE: begin
          if (release_out) begin
            dbz <= 1'b0;
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

  // Outputs are registered state; they hold while DONE waits for out_ready.
  always_comb begin
    in_ready    = (state == IDLE);
    out_valid   = (state == DONE);
    quotient    = q;
    remainder   = r;
    div_by_zero = dbz;
  end

endmodule

// File: tb/tb_seq_divider16by8.sv
// Scoreboard bench for seq_divider16by8: expectations are pushed on the input
// handshake and popped when the result is presented.
module tb_seq_divider16by8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } exp_t;

  exp_t sb[$];

  seq_divider16by8 #(.N_WIDTH(16), .D_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1);
  end

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 8'd0) begin
      e.q = 16'hFFFF;
      e.r = a[7:0];
      e.z = 1'b1;
    end else begin
      e.q = a / {8'd0, b};
      e.r = 8'(a % {8'd0, b});
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and wait (bounded) for acceptance; pushes the
  // expected result on the accepting edge.
  task automatic accept(input logic [15:0] a, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(a, b));
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; lat = edges elapsed after the accept edge.
  // Returns positioned at the negedge where out_valid was seen.
  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    dividend = '0;
    divisor = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'd0, 8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b q=%0d r=%0d z=%0b expected rdy=1 vld=0 q=0 r=0 z=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    step();
  endtask

  // Directed divisions with out_ready high; checks latency and result.
  task automatic test_basic(input string tag, input int n,
                            input logic [15:0] as[4], input logic [7:0] bs[4]);
    bit ok;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      accept(as[i], bs[i], ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL %s_accept: got no accept expected accept for %0d/%0d", tag, as[i], bs[i]);
      end
      wait_out(lat, ok);
      tests_run++;
      if (!ok || lat != 16) begin
        tests_failed++;
        $display("FAIL %s_latency: got %0d (seen=%0b) expected 16 for %0d/%0d", tag, lat, ok, as[i], bs[i]);
      end
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL %s_scoreboard: got empty queue expected an entry", tag);
      end else begin
        e = sb.pop_front();
        tests_run++;
        if (quotient !== e.q) begin
          tests_failed++;
          $display("FAIL %s_quotient %0d/%0d: got %0d expected %0d", tag, e.a, e.b, quotient, e.q);
        end
        tests_run++;
        if (remainder !== e.r) begin
          tests_failed++;
          $display("FAIL %s_remainder %0d/%0d: got %0d expected %0d", tag, e.a, e.b, remainder, e.r);
        end
        tests_run++;
        if (div_by_zero !== e.z) begin
          tests_failed++;
          $display("FAIL %s_dbz %0d/%0d: got %0b expected %0b", tag, e.a, e.b, div_by_zero, e.z);
        end
      end
      step();
    end
  endtask

  task automatic test_div_zero();
    bit ok;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    accept(16'h1234, 8'd0, ok);
    wait_out(lat, ok);
    // The result is visible in the cycle right after the accepting edge.
    tests_run++;
    if (!ok || lat != 0) begin
      tests_failed++;
      $display("FAIL dz_latency: got %0d edges (seen=%0b) expected 0 edges after accept", lat, ok);
    end
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL dz_scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      tests_run++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
        tests_failed++;
        $display("FAIL dz_result: got q=%h r=%h z=%0b expected q=%h r=%h z=%0b",
                 quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
    end
    step();
    @(negedge clk);
    tests_run++;
    if ({out_valid, div_by_zero, in_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL dz_clear: got vld=%0b z=%0b rdy=%0b expected vld=0 z=0 rdy=1",
               out_valid, div_by_zero, in_ready);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    exp_t e;
    out_ready = 1'b0;
    accept(16'd1000, 8'd7, ok);
    wait_out(lat, ok);
    tests_run++;
    if (!ok || sb.size() != 1) begin
      tests_failed++;
      $display("FAIL bp_start: got seen=%0b queue=%0d expected seen=1 queue=1", ok, sb.size());
    end
    e = model(16'd1000, 8'd7);
    if (sb.size() != 0) e = sb.pop_front();
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      tests_run++;
      if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, e.q, e.r}) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d: got vld=%0b rdy=%0b q=%0d r=%0d expected vld=1 rdy=0 q=%0d r=%0d",
                 i, out_valid, in_ready, quotient, remainder, e.q, e.r);
      end
      step();
      if (i == 5) begin
        dividend = 16'd3;
        divisor  = 8'd1;
        in_valid = 1'b1;
      end
      if (i == 7) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_release: got vld=%0b rdy=%0b queue=%0d expected vld=0 rdy=1 queue=0",
               out_valid, in_ready, sb.size());
    end
    step();
    accept(16'd200, 8'd9, ok);
    wait_out(lat, ok);
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL bp_next: got empty queue expected next operation accepted");
    end else begin
      e = sb.pop_front();
      tests_run++;
      if (!ok || {quotient, remainder} !== {e.q, e.r}) begin
        tests_failed++;
        $display("FAIL bp_next_result: got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    accept(16'd500, 8'd3, ok);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, quotient} !== {1'b1, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("FAIL mid_reset: got rdy=%0b vld=%0b q=%0d expected rdy=1 vld=0 q=0",
               in_ready, out_valid, quotient);
    end
    // The aborted operation produces no result.
    sb.delete();
    step();
    accept(16'd100, 8'd3, ok);
    wait_out(lat, ok);
    tests_run++;
    if (!ok || lat != 16) begin
      tests_failed++;
      $display("FAIL mid_latency: got %0d (seen=%0b) expected 16", lat, ok);
    end
    tests_run++;
    if (sb.size() != 1) begin
      tests_failed++;
      $display("FAIL mid_scoreboard: got %0d entries expected 1", sb.size());
    end else begin
      e = sb.pop_front();
      tests_run++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
        tests_failed++;
        $display("FAIL mid_result: got q=%0d r=%0d z=%0b expected q=%0d r=%0d z=%0b",
                 quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
    end
    step();
  endtask

  task automatic test_random(input int nops);
    int sent;
    int got;
    int cyc;
    bit acc;
    bit outh;
    int sel;
    exp_t e;
    sent = 0;
    got  = 0;
    cyc  = 0;
    in_valid = 1'b0;
    while ((sent < nops || got < sent) && cyc < 60000) begin
      if (!in_valid && sent < nops && $urandom_range(0, 2) == 0) begin
        sel = int'($urandom_range(0, 15));
        if (sel == 0)      divisor = 8'd0;
        else if (sel == 1) divisor = 8'd1;
        else if (sel == 2) divisor = 8'd255;
        else               divisor = 8'($urandom_range(1, 255));
        sel = int'($urandom_range(0, 7));
        if (sel == 0)      dividend = 16'd0;
        else if (sel == 1) dividend = 16'hFFFF;
        else if (sel == 2) dividend = 16'($urandom_range(0, 300));
        else               dividend = 16'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc  = in_valid && in_ready;
      outh = out_valid && out_ready;
      if (acc) begin
        sb.push_back(model(dividend, divisor));
        sent++;
      end
      if (outh) begin
        got++;
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL rnd_unexpected: got result q=%0d with empty queue expected none", quotient);
        end else begin
          e = sb.pop_front();
          tests_run++;
          if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
            tests_failed++;
            $display("FAIL rnd_result %0d/%0d: got q=%0d r=%0d z=%0b expected q=%0d r=%0d z=%0b",
                     e.a, e.b, quotient, remainder, div_by_zero, e.q, e.r, e.z);
          end
          if (e.b != 8'd0) begin
            tests_run++;
            if ((32'(quotient) * 32'(e.b) + 32'(remainder)) != 32'(e.a) || remainder >= e.b) begin
              tests_failed++;
              $display("FAIL rnd_identity %0d/%0d: got q=%0d r=%0d expected q*d+r=%0d and r<d",
                       e.a, e.b, quotient, remainder, e.a);
            end
          end
        end
      end
      step();
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    tests_run++;
    if (sent != nops || got != sent || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL rnd_counts: got sent=%0d results=%0d queue=%0d expected sent=%0d results=%0d queue=0",
               sent, got, sb.size(), nops, sent);
    end
  endtask

  initial begin
    logic [15:0] as[4];
    logic [7:0]  bs[4];
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    as = '{16'd1000, 16'd16129, 16'd0, 16'd0};
    bs = '{8'd7, 8'd127, 8'd0, 8'd0};
    test_basic("basic", 2, as, bs);
    as = '{16'd65535, 16'd65535, 16'd5, 16'd0};
    bs = '{8'd1, 8'd255, 8'd200, 8'd9};
    test_basic("extreme", 4, as, bs);
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random(1500);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
